// File: rtl/mccu_throttle_if.sv
// mccu_throttle_if: MCCU/core-side signal bundle for the throttle block.
// Build option: MCCU_THROTTLE_STATS_EN adds stall_cycles_o (per-core 32-bit stall-cycle counters).
interface mccu_throttle_if #(
  parameter int unsigned N_CORES   = 4,
  parameter int unsigned TIMEOUT_W = 16
);
  logic [N_CORES-1:0]   intr_MCCU_i;
  logic [N_CORES-1:0]   quota_refill_i;
  logic [N_CORES-1:0]   stall_ack_i;
  logic [TIMEOUT_W-1:0] release_cycles_i;
  logic [N_CORES-1:0]   timeout_clr_i;
  logic [N_CORES-1:0]   stall_req_o;
  logic [N_CORES-1:0]   timeout_o;
`ifdef MCCU_THROTTLE_STATS_EN
  logic [N_CORES*32-1:0] stall_cycles_o;
`endif

  // Environment side: MCCU and cores drive requests, observe throttle outputs
  modport master (
    output intr_MCCU_i, quota_refill_i, stall_ack_i, release_cycles_i, timeout_clr_i,
    input  stall_req_o, timeout_o
`ifdef MCCU_THROTTLE_STATS_EN
    , input stall_cycles_o
`endif
  );

  // Throttle side
  modport slave (
    input  intr_MCCU_i, quota_refill_i, stall_ack_i, release_cycles_i, timeout_clr_i,
    output stall_req_o, timeout_o
`ifdef MCCU_THROTTLE_STATS_EN
    , output stall_cycles_o
`endif
  );
endinterface

// File: rtl/mccu_throttle.sv
// mccu_throttle: per-core issue throttle driven by MCCU quota-exhausted interrupts.
// Each core runs IDLE -> REQ -> STALLED -> RELEASE; a stall ends on quota refill or
// when the stall window (release_cycles_i, 0 = unlimited) expires, the latter flagged
// in the sticky timeout_o.
// Build option: define MCCU_THROTTLE_STATS_EN to add stall_cycles_o, a saturating
// 32-bit count of STALLED cycles per core, cleared by timeout_clr_i.
module mccu_throttle #(
  parameter int unsigned N_CORES   = 4,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mccu_throttle_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_STALLED = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e               state_q [N_CORES];
  state_e               state_d [N_CORES];
  logic [TIMEOUT_W-1:0] cnt_q   [N_CORES];
  logic [TIMEOUT_W-1:0] cnt_d   [N_CORES];
  logic [N_CORES-1:0]   intr_q, intr_d;
  logic [N_CORES-1:0]   stall_req_q, stall_req_d;
  logic [N_CORES-1:0]   timeout_q, timeout_d;
  logic [N_CORES-1:0]   intr_rise_c;
  logic                 limit_en_c;
  logic [TIMEOUT_W-1:0] limit_m1_c;

  // Per-core next-state, stall-window counter and sticky timeout
  always_comb begin
    intr_d      = bus.intr_MCCU_i;
    intr_rise_c = bus.intr_MCCU_i & ~intr_q;
    limit_en_c  = (bus.release_cycles_i != '0);
    limit_m1_c  = bus.release_cycles_i - TIMEOUT_W'(1);
    timeout_d   = timeout_q & ~bus.timeout_clr_i;
    stall_req_d = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (intr_rise_c[i]) state_d[i] = ST_REQ;
        end
        ST_REQ: begin
          if (bus.quota_refill_i[i]) begin
            state_d[i] = ST_RELEASE;
          end else if (bus.stall_ack_i[i]) begin
            state_d[i] = ST_STALLED;
            cnt_d[i]   = '0;
          end
        end
        ST_STALLED: begin
          if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + TIMEOUT_W'(1);
          // Refill has priority over the window expiring in the same cycle
          if (bus.quota_refill_i[i]) begin
            state_d[i] = ST_RELEASE;
          end else if (limit_en_c && (cnt_q[i] >= limit_m1_c)) begin
            state_d[i]   = ST_RELEASE;
            timeout_d[i] = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!bus.stall_ack_i[i]) state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
      stall_req_d[i] = (state_d[i] == ST_REQ) || (state_d[i] == ST_STALLED);
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      intr_q      <= '0;
      stall_req_q <= '0;
      timeout_q   <= '0;
      for (int unsigned i = 0; i < N_CORES; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      intr_q      <= intr_d;
      stall_req_q <= stall_req_d;
      timeout_q   <= timeout_d;
      for (int unsigned i = 0; i < N_CORES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.stall_req_o = stall_req_q;
  assign bus.timeout_o   = timeout_q;

`ifdef MCCU_THROTTLE_STATS_EN
  localparam int unsigned STAT_W = 32;

  logic [STAT_W-1:0] stat_q [N_CORES];
  logic [STAT_W-1:0] stat_d [N_CORES];

  // Saturating STALLED-cycle counters, cleared together with the timeout flag
  always_comb begin
    for (int unsigned i = 0; i < N_CORES; i++) begin
      stat_d[i] = stat_q[i];
      if ((state_q[i] == ST_STALLED) && (stat_q[i] != '1)) stat_d[i] = stat_q[i] + STAT_W'(1);
      if (bus.timeout_clr_i[i]) stat_d[i] = '0;
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N_CORES; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CORES; i++) stat_q[i] <= stat_d[i];
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_stat_out
    assign bus.stall_cycles_o[g*STAT_W +: STAT_W] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_mccu_throttle.sv
// tb_mccu_throttle: directed scenarios plus randomized traffic; a transaction-level
// model predicts outputs per cycle into a queue, a monitor compares after each edge.
module tb_mccu_throttle;
  localparam int unsigned N  = 4;
  localparam int unsigned TW = 16;

  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_STALL = 2;
  localparam int M_REL   = 3;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  mccu_throttle_if #(.N_CORES(N), .TIMEOUT_W(TW)) bus ();

  mccu_throttle #(.N_CORES(N), .TIMEOUT_W(TW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct packed {
    logic [N*32-1:0] stats;
    logic [N-1:0]    to;
    logic [N-1:0]    stall;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  // reference model state
  int     mode    [N];
  int     elapsed [N];
  bit     prev    [N];
  bit     to_m    [N];
  longint st_m    [N];

  // random stimulus state
  logic [N-1:0]  r_intr, r_ack, r_ref, r_clr;
  logic [TW-1:0] r_rel;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mode[i] = M_IDLE; elapsed[i] = 0; prev[i] = 1'b0; to_m[i] = 1'b0; st_m[i] = 0;
    end
  endfunction

  function automatic void model_step(input logic [N-1:0] intr, input logic [N-1:0] refill,
                                     input logic [N-1:0] ack, input logic [N-1:0] clr,
                                     input logic [TW-1:0] rel);
    for (int i = 0; i < N; i++) begin
      bit rise;
      bit set_to;
      int was;
      rise   = intr[i] && !prev[i];
      prev[i] = intr[i];
      set_to = 1'b0;
      was    = mode[i];
      case (mode[i])
        M_IDLE: if (rise) mode[i] = M_REQ;
        M_REQ: begin
          if (refill[i]) mode[i] = M_REL;
          else if (ack[i]) begin mode[i] = M_STALL; elapsed[i] = 0; end
        end
        M_STALL: begin
          if (refill[i]) mode[i] = M_REL;
          else if (rel != 0 && elapsed[i] >= int'(rel) - 1) begin mode[i] = M_REL; set_to = 1'b1; end
          else if (elapsed[i] < 65535) elapsed[i]++;
        end
        default: if (!ack[i]) mode[i] = M_IDLE;
      endcase
      if (set_to) to_m[i] = 1'b1;
      else if (clr[i]) to_m[i] = 1'b0;
      if (was == M_STALL && st_m[i] < 64'hFFFF_FFFF) st_m[i]++;
      if (clr[i]) st_m[i] = 0;
    end
  endfunction

  // One cycle: drive at the falling edge, predict the post-edge outputs
  task automatic step(input bit rst, input logic [N-1:0] intr, input logic [N-1:0] refill,
                      input logic [N-1:0] ack, input logic [N-1:0] clr, input logic [TW-1:0] rel);
    exp_t e;
    @(negedge clk_i);
    rst_i                = rst;
    bus.intr_MCCU_i      = intr;
    bus.quota_refill_i   = refill;
    bus.stall_ack_i      = ack;
    bus.timeout_clr_i    = clr;
    bus.release_cycles_i = rel;
    if (rst) model_reset();
    else model_step(intr, refill, ack, clr, rel);
    for (int i = 0; i < N; i++) begin
      e.stall[i]          = (mode[i] == M_REQ) || (mode[i] == M_STALL);
      e.to[i]             = to_m[i];
      e.stats[i*32 +: 32] = 32'(st_m[i]);
    end
    expq.push_back(e);
    if (rst) begin
      #1;
      chk("async_rst_stall_req", 128'(bus.stall_req_o), 128'(0));
      chk("async_rst_timeout", 128'(bus.timeout_o), 128'(0));
    end
  endtask

  task automatic sample();
    @(posedge clk_i);
    #2;
  endtask

  // Monitor: pops one prediction per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (mon_en) begin
        if (expq.size() == 0) begin
          errors++; checks++;
          $display("FAIL scoreboard_empty: got no prediction, required one (t=%0t)", $time);
        end else begin
          e = expq.pop_front();
          chk("stall_req_o", 128'(bus.stall_req_o), 128'(e.stall));
          chk("timeout_o", 128'(bus.timeout_o), 128'(e.to));
`ifdef MCCU_THROTTLE_STATS_EN
          chk("stall_cycles_o", 128'(bus.stall_cycles_o), 128'(e.stats));
`endif
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst_i = 1'b1;
    bus.intr_MCCU_i = '0; bus.quota_refill_i = '0; bus.stall_ack_i = '0;
    bus.timeout_clr_i = '0; bus.release_cycles_i = '0;
    model_reset();

    // Reset and core 0 rising edge, then a 10-cycle timeout window
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd10);
    mon_en = 1'b1;
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd10);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd10);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd10);
    step(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 16'd10);
    sample();
    chk("req_after_edge", 128'(bus.stall_req_o), 128'(4'b0001));
    step(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 16'd10);
    step(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'd10);
    hi = 0;
    for (int k = 0; k < 14; k++) begin
      sample();
      if (bus.stall_req_o[0]) hi++;
      step(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'd10);
    end
    chk("stall_window_cycles", 128'(hi), 128'(10));
    chk("timeout_set", 128'(bus.timeout_o), 128'(4'b0001));
    for (int k = 0; k < 3; k++) step(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 16'd10);
    sample();
    chk("no_restall_on_level", 128'(bus.stall_req_o), 128'(0));

    // Core 3: refill on the cycle the window expires wins, no timeout
    step(0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 16'd4);
    step(0, 4'b1001, 4'b0000, 4'b1000, 4'b0000, 16'd4);
    for (int k = 0; k < 3; k++) step(0, 4'b1001, 4'b0000, 4'b1000, 4'b0000, 16'd4);
    step(0, 4'b1001, 4'b1000, 4'b1000, 4'b0000, 16'd4);
    sample();
    chk("refill_beats_timeout", 128'(bus.timeout_o), 128'(4'b0001));
    chk("refill_releases", 128'(bus.stall_req_o), 128'(0));
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd0);

    // Core 1: async reset mid-stall, then the held level re-triggers
    step(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 16'd0);
    step(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 16'd0);
    step(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 16'd0);
    step(1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 16'd0);
    step(1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 16'd0);
    step(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 16'd0);
    sample();
    chk("retrigger_after_reset", 128'(bus.stall_req_o), 128'(4'b0010));
    step(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 16'd0);
    step(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 16'd0);

    // Core 1: two 5-cycle stalls ended by refill
    for (int r = 0; r < 2; r++) begin
      step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'd0);
      step(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 16'd0);
      step(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 16'd0);
      for (int k = 0; k < 4; k++) step(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 16'd0);
      step(0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 16'd0);
      step(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 16'd0);
    end
`ifdef MCCU_THROTTLE_STATS_EN
    sample();
    chk("stats_two_stalls", 128'(bus.stall_cycles_o[63:32]), 128'(10));
`endif
    step(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 16'd0);
`ifdef MCCU_THROTTLE_STATS_EN
    sample();
    chk("stats_cleared", 128'(bus.stall_cycles_o[63:32]), 128'(0));
`endif

    // Core 2: unlimited window, counter saturates without a timeout
    step(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 16'd0);
    step(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 16'd0);
    for (int k = 0; k < 70000; k++) step(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 16'd0);
    sample();
    chk("long_stall_held", 128'(bus.stall_req_o), 128'(4'b0100));
    chk("long_stall_no_timeout", 128'(bus.timeout_o), 128'(0));
    step(0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 16'd0);
    sample();
    chk("long_stall_refill", 128'(bus.stall_req_o), 128'(0));
    step(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 16'd0);

    // Randomized traffic on all cores
    r_intr = 4'b0100; r_ack = '0; r_ref = '0; r_clr = '0; r_rel = 16'd6;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) r_intr[i] = ~r_intr[i];
        if ($urandom_range(3) == 0) r_ack[i] = ~r_ack[i];
        r_ref[i] = ($urandom_range(19) == 0);
        r_clr[i] = ($urandom_range(15) == 0);
      end
      if ($urandom_range(49) == 0) r_rel = TW'($urandom_range(12));
      step(($urandom_range(499) == 0), r_intr, r_ref, r_ack, r_clr, r_rel);
    end

    sample();
    mon_en = 1'b0;
    chk("queue_drained", 128'(expq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
